multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle sequencer for the ARMv4 datapath: one ALU, one memory port, IR and PC registers, all shared across cycles.
//  Decodes Instruction[31:12] and steps a Moore FSM through fetch/decode/execute/writeback.
//  Drives every mux select and write enable. Holds the NZCV flags register and evaluates the condition field.
// PARAMETERS
//  none. Encodings are fixed in mc_ctrl_pkg.
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  reset        in   1   asynchronous, active-low reset
//  Instr        in   20  IR bits [31:12]: cond[19:16] op[15:14] funct[13:8] Rd[3:0]
//  ALUFlags     in   4   {N,Z,C,V} from the ALU in the current cycle
//  mem_ready    in   1   memory handshake; honoured only with MC_MEM_WAIT_EN
//  PCWrite      out  1   load PC
//  AdrSrc       out  1   memory address: 0=PC, 1=ALU result register
//  MemWrite     out  1   memory write strobe
//  IRWrite      out  1   load IR from memory read data
//  RegWrite     out  1   register-file write enable
//  ResultSrc    out  2   00=ALUOut reg, 01=read-data reg, 10=ALU direct
//  ALUSrcA      out  1   0=RD1, 1=PC
//  ALUSrcB      out  2   00=RD2, 01=ExtImm, 10=const 4
//  ALUControl   out  4   ALU opcode (mc_ctrl_pkg)
//  ImmSrc       out  2   equals op (00 imm8, 01 imm12, 10 imm24)
//  RegSrc       out  2   [0]=branch (A1<-R15), [1]=store (A2<-Rd)
//  instr_done   out  1   1-cycle pulse when an instruction retires
//  illegal_instr out 1   1-cycle pulse in DECODE for op==11 or an unsupported cmd
// BEHAVIOUR
//  - Reset low (async): state=FETCH, flags=0000; every output is 0 while reset is low, including write enables.
//  - First active cycle after reset release is FETCH.
//  - CondEx = cond_check(cond, flags). Cond 1110 is always true; 1111 is treated as false.
//  - States and actions (no assertion listed = 0):
//    FETCH:  AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE
//    DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10
//            op==11, illegal cmd, or !CondEx -> FETCH, with instr_done=1 (illegal_instr=1 if illegal)
//            op==01 -> MEMADR; op==10 -> BRANCH; op==00 -> funct[5] ? EXECI : EXECR
//    MEMADR: ALUSrcA=0, ALUSrcB=01, ADD -> funct[0] ? MEMRD : MEMWR
//    MEMRD:  AdrSrc=1 -> MEMWB
//    MEMWB:  ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH
//    MEMWR:  AdrSrc=1, MemWrite=1, instr_done=1 -> FETCH
//    EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALUControl=decode(cmd) -> ALUWB
//            CMP -> FETCH, with instr_done=1
//    ALUWB:  ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH
//    BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1, instr_done=1 -> FETCH
//  - PC writeback: in ALUWB/MEMWB with Rd==15, PCWrite is also 1.
//  - cmd=funct[4:1] decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (ALU SUB).
//    Any other cmd is illegal.
//  - Flags: in EXECR/EXECI, flags <= ALUFlags when funct[0] (S) or cmd==CMP.
//    Flags update in no other state.
//  - Cycle counts: branch 3, data-processing 4 (CMP 3), LDR 5, STR 4, skipped instruction 2.
//  - Reset mid-instruction: abandons immediately; no write enable is asserted after reset falls.
// CONFIGURATION
//  - MC_MEM_WAIT_EN defined: FETCH, MEMRD and MEMWR hold while mem_ready==0.
//    MemWrite and AdrSrc stay asserted while holding.
//    IRWrite, PCWrite and instr_done assert only in the cycle with mem_ready==1; the transition happens then.
//  - MC_MEM_WAIT_EN undefined: mem_ready is ignored; every memory state takes exactly 1 cycle.
// STRUCTURE
//  - mc_ctrl_pkg: state_t enum, ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_ORR=4'b0011,
//    RES_ALUOUT/RES_RDATA/RES_ALU, SRCB_REG/SRCB_IMM/SRCB_4, cmd codes.
//  - Sub-module cond_check: combinational cond + NZCV -> CondEx.
//  - Top: state register, flags register, next-state logic, output decode.
// TESTING
//  1. reset low with FETCH-type stimulus -> all outputs 0.
//     Release -> FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10.
//  2. ADD R1,R2,#5 (Instr=20'hE2821) -> states F,D,EXECI,ALUWB.
//     ALUControl=0000 in EXECI; RegWrite=1 in cycle 4; instr_done once.
//  3. SUBS sets Z (ALUFlags=4'b0100), then BEQ (Instr=20'h0A000) -> BRANCH with PCWrite=1.
//     Same BEQ with Z=0 -> DECODE->FETCH, PCWrite=0.
//  4. LDR R3,[R0,#8] -> F,D,MEMADR,MEMRD,MEMWB, with AdrSrc=1 in MEMRD.
//     STR -> MemWrite=1 for exactly 1 cycle.
//  5. MC_MEM_WAIT_EN: mem_ready low 3 cycles in MEMWR -> MemWrite high 4 cycles, instr_done once at the end.
//     op==11 -> illegal_instr pulse, back to FETCH.
//  6. Assert reset in MEMWR -> MemWrite drops asynchronously; after release, state=FETCH and flags=0000.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARMv4 control sequencer:
// FSM states, ALU opcodes, mux select codes, instruction classes and
// data-processing command codes, plus the command decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // True for the data-processing commands this datapath implements.
  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_CMP) || (cmd == CMD_ORR);
  endfunction

  // Maps a command to its ALU opcode; CMP is a subtract whose result is dropped.
  function automatic logic [3:0] cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_cond_check.sv
// Condition-field evaluator: combines the 4-bit ARM condition code with
// the stored NZCV flags. 1110 (AL) is always true; 1111 is treated as never.
module cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Condition table lookup.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      4'b0000: cond_ex_o = z;
      4'b0001: cond_ex_o = ~z;
      4'b0010: cond_ex_o = c;
      4'b0011: cond_ex_o = ~c;
      4'b0100: cond_ex_o = n;
      4'b0101: cond_ex_o = ~n;
      4'b0110: cond_ex_o = v;
      4'b0111: cond_ex_o = ~v;
      4'b1000: cond_ex_o = c & ~z;
      4'b1001: cond_ex_o = ~c | z;
      4'b1010: cond_ex_o = ~(n ^ v);
      4'b1011: cond_ex_o = n ^ v;
      4'b1100: cond_ex_o = ~z & ~(n ^ v);
      4'b1101: cond_ex_o = z | (n ^ v);
      4'b1110: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARMv4 control sequencer: Moore FSM stepping fetch/decode/
// execute/writeback, NZCV flags register and every datapath select/enable.
// Optional build macro MC_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall while
// mem_ready is low; without it mem_ready is ignored.
// All outputs are forced to 0 while the asynchronous reset is low.
module multicycle_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        instr_done,
  output logic        illegal_instr
);
  import mc_ctrl_pkg::*;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic [3:0]  rd;
  logic        cond_ex;
  logic        illegal;
  logic        is_cmp;
  logic        mem_ok;
  logic [3:0]  unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = Instr[7:4];
  assign cmd       = funct[4:1];
  assign is_cmp    = (cmd == CMD_CMP);
  assign illegal   = (op == OP_ILL) || ((op == OP_DP) && !cmd_legal(cmd));

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  cond_check u_cond_check (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // State and flags registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Next-state, flags update and Moore output decode, gated off during reset.
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    ALUControl    = ALU_ADD;
    ImmSrc        = op;
    RegSrc        = {(op == OP_MEM) && !funct[0], op == OP_BR};
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        if (mem_ok) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        if (illegal || !cond_ex) begin
          instr_done    = 1'b1;
          illegal_instr = illegal;
          state_d       = S_FETCH;
        end else if (op == OP_MEM) begin
          state_d = S_MEMADR;
        end else if (op == OP_BR) begin
          state_d = S_BRANCH;
        end else begin
          state_d = funct[5] ? S_EXECI : S_EXECR;
        end
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_RDATA;
        RegWrite   = 1'b1;
        PCWrite    = (rd == 4'd15);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ok) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = cmd_to_alu(cmd);
        if (funct[0] || is_cmp) flags_d = ALUFlags;
        if (is_cmp) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        PCWrite    = (rd == 4'd15);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!reset) begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUControl    = 4'b0000;
      ImmSrc        = 2'b00;
      RegSrc        = 2'b00;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed walk through each instruction
// class, reset behaviour and (with MC_MEM_WAIT_EN) memory stalls, followed
// by a random instruction stream checked against a per-instruction model.
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic        ALUSrcA;
  logic [3:0]  ALUControl;
  logic        instr_done, illegal_instr;
  logic [19:0] outs;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .Instr         (Instr),
    .ALUFlags      (ALUFlags),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUControl    (ALUControl),
    .ImmSrc        (ImmSrc),
    .RegSrc        (RegSrc),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, RegSrc, instr_done, illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // SUBS R0,R0,R0 from FETCH back to the next FETCH, ALU reporting f in execute.
  task automatic run_subs(input logic [3:0] f);
    Instr = 20'hE0500;
    cyc();
    cyc();
    ALUFlags = f;
    #1;
    chk("subs_e_aluctl", ALUControl, 4'b0001);
    chk("subs_e_srcb", ALUSrcB, 2'b00);
    cyc();
    ALUFlags = 4'b0000;
    chk("subs_wb_rw", RegWrite, 1'b1);
    cyc();
  endtask

  // Reference condition evaluation, grouped by condition pairs.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Runs one instruction from FETCH until instr_done (bounded), tallying enables.
  task automatic run_instr(input logic [19:0] ins, output int cycles, output int rw,
                           output int mw, output int pc, output int ir, output int ill,
                           output logic [3:0] cap);
    bit done;
    cycles = 0; rw = 0; mw = 0; pc = 0; ir = 0; ill = 0; cap = 4'h0; done = 0;
    Instr = ins;
    while (!done && cycles < 16) begin
      ALUFlags = 4'($urandom);
`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b1;
`else
      mem_ready = 1'($urandom);
`endif
      #1;
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      pc += int'(PCWrite);
      ir += int'(IRWrite);
      ill += int'(illegal_instr);
      if (cycles == 2) cap = ALUFlags;
      if (instr_done) done = 1;
      cycles++;
      cyc();
    end
  endtask

  initial begin
    logic [3:0]  mflags;
    logic [19:0] ins;
    logic [3:0]  cond, cmd, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    int          pick;
    int          cycles, rw, mw, pc, ir, ill;
    int          e_cyc, e_rw, e_mw, e_pc, e_ill;
    logic [3:0]  cap;
    bit          illegal, cex;
    logic [3:0]  cmds [6];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0000;

    // 1. Reset held low with FETCH-type stimulus, then release.
    reset = 1'b0; Instr = 20'hE2821; ALUFlags = 4'b0000; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs", outs, 20'h0);
    reset = 1'b1;
    #1;
    chk("f_irw", IRWrite, 1'b1);
    chk("f_pcw", PCWrite, 1'b1);
    chk("f_srcb", ALUSrcB, 2'b10);
    chk("f_srca", ALUSrcA, 1'b1);
    chk("f_adr", AdrSrc, 1'b0);
    chk("f_res", ResultSrc, 2'b10);

    // 2. ADD R1,R2,#5.
    cyc();
    chk("add_d_srca", ALUSrcA, 1'b1);
    chk("add_d_done", instr_done, 1'b0);
    cyc();
    chk("add_e_aluctl", ALUControl, 4'b0000);
    chk("add_e_srcb", ALUSrcB, 2'b01);
    chk("add_e_srca", ALUSrcA, 1'b0);
    chk("add_e_rw", RegWrite, 1'b0);
    cyc();
    chk("add_wb_rw", RegWrite, 1'b1);
    chk("add_wb_done", instr_done, 1'b1);
    chk("add_wb_res", ResultSrc, 2'b00);
    chk("add_wb_pcw", PCWrite, 1'b0);
    cyc();
    chk("add_f_irw", IRWrite, 1'b1);

    // 3. SUBS setting Z, BEQ taken; SUBS clearing Z, BEQ skipped.
    run_subs(4'b0100);
    Instr = 20'h0A000;
    cyc();
    chk("beq_d_done", instr_done, 1'b0);
    chk("beq_d_regsrc", RegSrc, 2'b01);
    chk("beq_d_immsrc", ImmSrc, 2'b10);
    cyc();
    chk("beq_b_pcw", PCWrite, 1'b1);
    chk("beq_b_res", ResultSrc, 2'b10);
    chk("beq_b_done", instr_done, 1'b1);
    cyc();
    run_subs(4'b0000);
    Instr = 20'h0A000;
    cyc();
    chk("beqnt_d_done", instr_done, 1'b1);
    chk("beqnt_d_pcw", PCWrite, 1'b0);
    chk("beqnt_d_ill", illegal_instr, 1'b0);
    cyc();
    chk("beqnt_f_irw", IRWrite, 1'b1);

    // 4. LDR R3,[R0,#8] then STR R3,[R0,#8].
    Instr = 20'hE5903;
    cyc();
    chk("ldr_d_immsrc", ImmSrc, 2'b01);
    chk("ldr_d_regsrc", RegSrc, 2'b00);
    cyc();
    chk("ldr_ma_srcb", ALUSrcB, 2'b01);
    chk("ldr_ma_srca", ALUSrcA, 1'b0);
    cyc();
    chk("ldr_rd_adr", AdrSrc, 1'b1);
    chk("ldr_rd_done", instr_done, 1'b0);
    cyc();
    chk("ldr_wb_res", ResultSrc, 2'b01);
    chk("ldr_wb_rw", RegWrite, 1'b1);
    chk("ldr_wb_done", instr_done, 1'b1);
    cyc();
    Instr = 20'hE5803;
    cyc();
    chk("str_d_regsrc", RegSrc, 2'b10);
    chk("str_d_memw", MemWrite, 1'b0);
    cyc();
    chk("str_ma_memw", MemWrite, 1'b0);
    cyc();
    mem_ready = 1'b0;
    #1;
`ifdef MC_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      chk("strw_hold_memw", MemWrite, 1'b1);
      chk("strw_hold_adr", AdrSrc, 1'b1);
      chk("strw_hold_done", instr_done, 1'b0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("strw_last_memw", MemWrite, 1'b1);
    chk("strw_last_done", instr_done, 1'b1);
    cyc();
    chk("strw_f_memw", MemWrite, 1'b0);
    // FETCH stall.
    mem_ready = 1'b0;
    #1;
    chk("fw_hold_irw", IRWrite, 1'b0);
    chk("fw_hold_pcw", PCWrite, 1'b0);
    cyc();
    chk("fw_hold2_irw", IRWrite, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("fw_rel_irw", IRWrite, 1'b1);
`else
    chk("str_wr_memw", MemWrite, 1'b1);
    chk("str_wr_adr", AdrSrc, 1'b1);
    chk("str_wr_done", instr_done, 1'b1);
    cyc();
    chk("str_f_memw", MemWrite, 1'b0);
    chk("str_f_irw", IRWrite, 1'b1);
    mem_ready = 1'b1;
`endif

    // 5. op==11 and an unsupported command (EOR).
    Instr = 20'hEC000;
    cyc();
    chk("op11_d_ill", illegal_instr, 1'b1);
    chk("op11_d_done", instr_done, 1'b1);
    cyc();
    chk("op11_f_ill", illegal_instr, 1'b0);
    chk("op11_f_irw", IRWrite, 1'b1);
    Instr = 20'hE0200;
    cyc();
    chk("eor_d_ill", illegal_instr, 1'b1);
    cyc();

    // 6. Reset during MEMWR with Z set beforehand.
    run_subs(4'b0100);
    Instr = 20'hE5803;
    cyc();
    cyc();
    cyc();
    chk("rstwr_memw", MemWrite, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rstwr_async_outs", outs, 20'h0);
    cyc();
    chk("rstwr_held_outs", outs, 20'h0);
    reset = 1'b1;
    #1;
    chk("rstwr_f_irw", IRWrite, 1'b1);
    chk("rstwr_f_srcb", ALUSrcB, 2'b10);
    Instr = 20'h0A000;
    cyc();
    chk("rstwr_beq_done", instr_done, 1'b1);
    chk("rstwr_beq_pcw", PCWrite, 1'b0);
    cyc();
    Instr = 20'h1A000;
    cyc();
    chk("rstwr_bne_d_done", instr_done, 1'b0);
    cyc();
    chk("rstwr_bne_b_pcw", PCWrite, 1'b1);
    cyc();

    // Random instruction stream against the per-instruction model.
    mflags = 4'b0000;
    for (int k = 0; k < 150; k++) begin
      cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
      rd   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 4) begin
        op  = 2'b00;
        cmd = (pick == 4) ? 4'($urandom) : cmds[$urandom_range(0, 5)];
        funct = {1'($urandom), cmd, 1'($urandom)};
      end else if (pick <= 6) begin
        op = 2'b01;
        funct = 6'($urandom);
      end else if (pick <= 8) begin
        op = 2'b10;
        funct = 6'($urandom);
      end else begin
        op = 2'b11;
        funct = 6'($urandom);
      end
      ins = {cond, op, funct, 4'($urandom), rd};

      cmd     = funct[4:1];
      illegal = (op == 2'b11) ||
                (op == 2'b00 && !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}));
      cex     = cond_true(cond, mflags);
      e_rw = 0; e_mw = 0; e_ill = 0; e_pc = 1;
      if (illegal || !cex) begin
        e_cyc = 2;
        e_ill = illegal ? 1 : 0;
      end else if (op == 2'b10) begin
        e_cyc = 3;
        e_pc  = 2;
      end else if (op == 2'b01) begin
        if (funct[0]) begin
          e_cyc = 5; e_rw = 1; e_pc = (rd == 4'd15) ? 2 : 1;
        end else begin
          e_cyc = 4; e_mw = 1;
        end
      end else if (cmd == 4'b1010) begin
        e_cyc = 3;
      end else begin
        e_cyc = 4; e_rw = 1; e_pc = (rd == 4'd15) ? 2 : 1;
      end

      run_instr(ins, cycles, rw, mw, pc, ir, ill, cap);
      chk($sformatf("rnd%0d_%05h_cycles", k, ins), cycles, e_cyc);
      chk($sformatf("rnd%0d_%05h_regwrite", k, ins), rw, e_rw);
      chk($sformatf("rnd%0d_%05h_memwrite", k, ins), mw, e_mw);
      chk($sformatf("rnd%0d_%05h_pcwrite", k, ins), pc, e_pc);
      chk($sformatf("rnd%0d_%05h_irwrite", k, ins), ir, 1);
      chk($sformatf("rnd%0d_%05h_illegal", k, ins), ill, e_ill);

      if (!illegal && cex && op == 2'b00 && (funct[0] || cmd == 4'b1010))
        mflags = cap;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
